sevenseg_scanner: RTL and testbench
===================================

# sevenseg_scanner

Parametrised multiplexed seven-segment display driver for the SweRVolf board toplevels. It time-multiplexes `NUM_DIGITS` hex digits onto shared segment lines. A prescaled per-digit refresh period includes an anode dead-time interval to suppress ghosting. Display data is double-buffered so updates never tear mid-frame, and per-digit blanking, decimal points and leading-zero suppression are supported. It sits in the board toplevel, driven from GPIO or debug counters, and replaces ad-hoc per-clock anode rotation.

## Interface

- `NUM_DIGITS`, 8: digits driven, 1..16.
- `PRESCALE`, 50000: clk cycles per digit slot, ≥2.
- `DEAD_CYCLES`, 500: cycles at slot start with all anodes inactive, < `PRESCALE`.
- `ACTIVE_LOW`, 1: 1 = anodes, segments and dp asserted low; 0 = asserted high.

- `clk` in 1: core clock; the block is single-clock.
- `rstn` in 1: asynchronous, active-low reset.
- `i_enable` in 1: scan enable.
- `i_load` in 1: one-cycle strobe that captures `i_value`, `i_dp` and `i_blank` into the pending buffer.
- `i_value` in 4*NUM_DIGITS: hex nibbles; digit k = [4k+3:4k], digit 0 rightmost.
- `i_dp` in NUM_DIGITS: decimal point per digit.
- `i_blank` in NUM_DIGITS: force digit dark.
- `i_lzs` in 1: leading-zero suppression; live, not buffered.
- `o_an` out NUM_DIGITS: anode drives.
- `o_seg` out 7: segments; [6]=a … [0]=g.
- `o_dp` out 1: decimal point.
- `o_frame` out 1: one-cycle pulse at frame wrap.
- `o_pending` out 1: pending buffer not yet applied.

## Operation

- **Counters.** Prescaler `p` counts 0..PRESCALE-1. Digit index `d` increments when `p` wraps and wraps from NUM_DIGITS-1 to 0.
- **Frame boundary.** The boundary is the cycle where (d,p) goes from (NUM_DIGITS-1, PRESCALE-1) to (0,0). `o_frame` pulses on that transition.
- **Double buffer.**
  - `i_load` writes the pending regs and sets `o_pending`.
  - At a boundary, if `o_pending` is set, pending is copied to active and `o_pending` clears.
  - Several loads before one boundary: the last load wins.
  - A load in the boundary cycle goes to pending, sets `o_pending`, and is applied at the next boundary. Any earlier pending value is overwritten and never shown.
- **Disabled state.**
  - With `i_enable` = 0: `p` = 0, `d` = 0, all anodes, segments and dp inactive.
  - Every disabled cycle counts as a boundary, so a pending load is applied on the next cycle.
  - On re-enable, scanning starts at digit 0 in its dead phase.
- **Slot phases.**
  - Dead phase, `p < DEAD_CYCLES`: all anodes inactive, segments and dp inactive.
  - Drive phase: anode d is asserted unless digit d is dark. `o_seg` shows the decode of active nibble d; `o_dp` = active dp[d].
- **Digit darkness.**
  - Digit d is dark if active blank[d] = 1. Explicit blank overrides everything, including dp.
  - LZS: with `i_lzs` = 1, digit d > 0 is suppressed when nibble d and all higher nibbles are 0. Digit 0 is never suppressed.
  - A suppressed digit whose dp bit is set keeps its anode on with segments off and dp on. Otherwise it is dark.
- **Decode.** Active-high patterns, abcdefg:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1111011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
- **Polarity.** With `ACTIVE_LOW` = 1, the anode, segment and dp outputs are inverted.
- **Reset values.**
  - `o_an`, `o_seg`, `o_dp` inactive: all ones when `ACTIVE_LOW` = 1.
  - `o_frame` = 0, `o_pending` = 0.
  - `p` = 0, `d` = 0; active and pending buffers = 0.
  - Reset mid-frame aborts immediately with no partial update.

## Timing

- All outputs are registered. Each output reflects the (d,p) state and active buffer of the previous cycle: 1-cycle latency.
- Anode on-time per slot is PRESCALE−DEAD_CYCLES cycles.
- Full frame length is NUM_DIGITS*PRESCALE cycles.
- The active buffer changes only in the cycle after a boundary, so the first drive cycle of digit 0 already shows new data.
- `o_pending` rises the cycle after `i_load`. It falls the cycle after the boundary that applies the load.
- `i_lzs` and `i_enable` take effect on the next output register update.

## Test plan

Common configuration: NUM_DIGITS=4, PRESCALE=8, DEAD_CYCLES=2, ACTIVE_LOW=1.

1. **Reset.** Assert rstn=0 → o_an=4'hF, o_seg=7'h7F, o_dp=1, o_frame=0, o_pending=0. Hold while clocking; outputs are unchanged.
2. **Load and scan.** Load 16'h12A0, enable → after the boundary, digit 0 slot shows o_an=4'hF for 2 cycles, then o_an=4'b1110 with o_seg=7'b0000001 for 6 cycles. Digit 1 shows A=7'b0001000, digit 3 shows 1=7'b1001111. o_frame pulses every 32 cycles.
3. **LZS.** Load 16'h0030 with i_lzs=1 → digits 3 and 2 keep their anodes high for the whole slot; digit 1 shows 3=7'b0000110; digit 0 shows 0. Load 16'h0000 → only digit 0 is lit. Load with i_dp=4'b1000 → digit 3 has anode low, o_seg=7'h7F, o_dp=0.
4. **Tear-free update.** Load 16'h1111 during digit 1's slot, then 16'h2222 during digit 2's slot → o_pending=1. Digits 1–3 keep the old data until o_frame; the next frame shows 2 on every digit; 1111 is never displayed.
5. **Boundary collision.** Assert i_load in the o_frame transition cycle → the value appears one frame later and o_pending stays 1 until then.
6. **Disable / reset mid-frame.** Drop i_enable during digit 2 → o_an=4'hF next cycle. Re-enable → digit 0 dead phase starts. Pulse rstn mid-slot → reset values, and the active buffer reads 0.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// sevenseg_scanner: multiplexed hex seven-segment driver.
// A prescaled per-digit slot with a leading dead time keeps adjacent digits
// from ghosting. Display data is double-buffered and swapped only at a frame
// boundary, so a frame never shows a mix of old and new data.
// All outputs are registered and show the previous cycle's scan state.
module sevenseg_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_enable,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lzs,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame,
  output logic                    o_pending
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

  // Hex nibble to active-high abcdefg pattern ([6]=a .. [0]=g).
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'b1111110;
      4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;
      4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;
      4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;
      4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1111011;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b0011111;
      4'hC: pat = 7'b1001110;
      4'hD: pat = 7'b0111101;
      4'hE: pat = 7'b1001111;
      4'hF: pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // Scan position
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] d_q, d_d;

  // Active (displayed) and pending buffers
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*NUM_DIGITS-1:0] pnd_val_q, pnd_val_d;
  logic [NUM_DIGITS-1:0]   pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0]   pnd_blank_q, pnd_blank_d;
  logic                    pnd_flag_q, pnd_flag_d;

  // Output registers
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic                  frame_q, frame_d;

  // Per-cycle decode of the current digit
  logic                  wrap_s;
  logic                  bound_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blank_s;
  logic                  upper_zero_s;
  logic                  supp_s;
  logic                  drive_s;
  logic                  lit_s;
  logic [NUM_DIGITS-1:0] an_on_s;
  logic [6:0]            seg_on_s;
  logic                  dp_on_s;

  // Counter advance, buffer swap at boundaries and pending capture.
  always_comb begin
    wrap_s  = (d_q == D_LAST) && (p_q == P_LAST);
    // A disabled cycle behaves as a boundary so a pending load lands promptly.
    bound_s = !i_enable || wrap_s;

    if (!i_enable) begin
      p_d = '0;
      d_d = '0;
    end else if (p_q == P_LAST) begin
      p_d = '0;
      d_d = (d_q == D_LAST) ? '0 : d_q + DW'(1);
    end else begin
      p_d = p_q + PW'(1);
      d_d = d_q;
    end

    // A load in the boundary cycle wins over the older pending data, which is
    // therefore discarded rather than shown for one frame.
    if (bound_s && pnd_flag_q && !i_load) begin
      act_val_d   = pnd_val_q;
      act_dp_d    = pnd_dp_q;
      act_blank_d = pnd_blank_q;
    end else begin
      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
    end

    if (i_load) begin
      pnd_val_d   = i_value;
      pnd_dp_d    = i_dp;
      pnd_blank_d = i_blank;
      pnd_flag_d  = 1'b1;
    end else if (bound_s) begin
      pnd_val_d   = pnd_val_q;
      pnd_dp_d    = pnd_dp_q;
      pnd_blank_d = pnd_blank_q;
      pnd_flag_d  = 1'b0;
    end else begin
      pnd_val_d   = pnd_val_q;
      pnd_dp_d    = pnd_dp_q;
      pnd_blank_d = pnd_blank_q;
      pnd_flag_d  = pnd_flag_q;
    end
  end

  // Digit selection, darkness rules and polarity of the next outputs.
  always_comb begin
    cur_nib_s    = 4'h0;
    cur_dp_s     = 1'b0;
    cur_blank_s  = 1'b0;
    upper_zero_s = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (d_q == DW'(k)) begin
        cur_nib_s   = act_val_q[4*k +: 4];
        cur_dp_s    = act_dp_q[k];
        cur_blank_s = act_blank_q[k];
      end
      if ((DW'(k) >= d_q) && (act_val_q[4*k +: 4] != 4'h0)) begin
        upper_zero_s = 1'b0;
      end
    end

    supp_s  = i_lzs && (d_q != '0) && upper_zero_s;
    drive_s = i_enable && (p_q >= P_DEAD);
    // A suppressed digit stays lit only to carry its decimal point.
    lit_s   = drive_s && !cur_blank_s && (!supp_s || cur_dp_s);

    an_on_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_on_s[k] = lit_s && (d_q == DW'(k));
    end

    if (drive_s && !cur_blank_s && !supp_s) begin
      seg_on_s = hex_decode(cur_nib_s);
    end else begin
      seg_on_s = 7'b0000000;
    end
    dp_on_s = drive_s && !cur_blank_s && cur_dp_s;

    an_d    = an_on_s ^ {NUM_DIGITS{POL}};
    seg_d   = seg_on_s ^ {7{POL}};
    dpo_d   = dp_on_s ^ POL;
    frame_d = i_enable && wrap_s;
  end

  // State and output registers; reset leaves the display dark and idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q         <= '0;
      d_q         <= '0;
      act_val_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      pnd_val_q   <= '0;
      pnd_dp_q    <= '0;
      pnd_blank_q <= '0;
      pnd_flag_q  <= 1'b0;
      an_q        <= {NUM_DIGITS{POL}};
      seg_q       <= {7{POL}};
      dpo_q       <= POL;
      frame_q     <= 1'b0;
    end else begin
      p_q         <= p_d;
      d_q         <= d_d;
      act_val_q   <= act_val_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      pnd_val_q   <= pnd_val_d;
      pnd_dp_q    <= pnd_dp_d;
      pnd_blank_q <= pnd_blank_d;
      pnd_flag_q  <= pnd_flag_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dpo_q       <= dpo_d;
      frame_q     <= frame_d;
    end
  end

  assign o_an      = an_q;
  assign o_seg     = seg_q;
  assign o_dp      = dpo_q;
  assign o_frame   = frame_q;
  assign o_pending = pnd_flag_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner (4 digits, 8-cycle slots, 2 dead cycles,
// active-low). A frame-position reference model checks every cycle; table
// vectors and hand sequences check specific display states.
module tb_sevenseg_scanner;
  localparam int N  = 4;
  localparam int P  = 8;
  localparam int DC = 2;
  localparam int FL = N * P;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        ld = 1'b0;
  logic        lzs = 1'b0;
  logic [15:0] val = 16'h0;
  logic [3:0]  dpi = 4'h0;
  logic [3:0]  blk = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dpo, frame, pend;

  sevenseg_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .DEAD_CYCLES(DC), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .i_enable(en), .i_load(ld), .i_value(val),
    .i_dp(dpi), .i_blank(blk), .i_lzs(lzs),
    .o_an(an), .o_seg(seg), .o_dp(dpo), .o_frame(frame), .o_pending(pend)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: frame position plus the two buffers.
  int          m_t;
  logic [15:0] m_val, p_val;
  logic [3:0]  m_dp, m_blk, p_dp, p_blk;
  logic        m_flag;
  logic [6:0]  seg_tab [16];

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
    logic        lz;
    int          dig;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_val = 16'h0; p_val = 16'h0;
    m_dp = 4'h0; m_blk = 4'h0; p_dp = 4'h0; p_blk = 4'h0; m_flag = 1'b0;
  endtask

  // One clock: predict, clock, compare, advance the model.
  task automatic tick();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame, e_flag, bnd, supp, c_en, c_ld, c_lzs;
    logic [15:0] up, c_val;
    logic [3:0]  c_dp, c_blk;
    int          dig, ph;
    c_en = en; c_ld = ld; c_lzs = lzs; c_val = val; c_dp = dpi; c_blk = blk;
    ph = m_t % P;
    dig = m_t / P;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (c_en && ph >= DC) begin
      up = m_val >> (4 * dig);
      supp = c_lzs && (dig > 0) && (up == 16'h0);
      if (!m_blk[dig]) begin
        if (!supp || m_dp[dig]) e_an[dig] = 1'b0;
        if (!supp) e_seg = ~seg_tab[up[3:0]];
        if (m_dp[dig]) e_dp = 1'b0;
      end
    end
    e_frame = c_en && (m_t == FL - 1);
    bnd = !c_en || (m_t == FL - 1);
    e_flag = c_ld ? 1'b1 : (bnd ? 1'b0 : m_flag);
    @(posedge clk);
    #1;
    chk("model_an", 32'(an), 32'(e_an));
    chk("model_seg", 32'(seg), 32'(e_seg));
    chk("model_dp", 32'(dpo), 32'(e_dp));
    chk("model_frame", 32'(frame), 32'(e_frame));
    chk("model_pending", 32'(pend), 32'(e_flag));
    if (bnd && m_flag && !c_ld) begin
      m_val = p_val; m_dp = p_dp; m_blk = p_blk;
    end
    if (c_ld) begin
      p_val = c_val; p_dp = c_dp; p_blk = c_blk;
    end
    m_flag = e_flag;
    m_t = c_en ? (m_t + 1) % FL : 0;
  endtask

  // Run until the pre-edge frame position equals target, then clock it.
  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (m_t != target && guard < 100) begin
      tick();
      guard++;
    end
    if (m_t != target) begin
      n_chk++;
      n_fail++;
      $display("FAIL goto: position %0d, expected %0d", m_t, target);
    end
    tick();
  endtask

  // Load new data while disabled so it is active when scanning restarts.
  task automatic apply(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
    en = 1'b0; ld = 1'b1; val = v; dpi = d; blk = b;
    tick();
    ld = 1'b0;
    tick();
    en = 1'b1; lzs = lz;
  endtask

  initial begin
    int cnt;
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    // digit 0 decode of every nibble (active-low expectations)
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0000001, 1'b1});
    vt.push_back('{16'h0001, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b1001111, 1'b1});
    vt.push_back('{16'h0002, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0010010, 1'b1});
    vt.push_back('{16'h0003, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0000110, 1'b1});
    vt.push_back('{16'h0004, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b1001100, 1'b1});
    vt.push_back('{16'h0005, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0100100, 1'b1});
    vt.push_back('{16'h0006, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0100000, 1'b1});
    vt.push_back('{16'h0007, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0001111, 1'b1});
    vt.push_back('{16'h0008, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0000000, 1'b1});
    vt.push_back('{16'h0009, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0000100, 1'b1});
    vt.push_back('{16'h000A, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0001000, 1'b1});
    vt.push_back('{16'h000B, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b1100000, 1'b1});
    vt.push_back('{16'h000C, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0110001, 1'b1});
    vt.push_back('{16'h000D, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b1000010, 1'b1});
    vt.push_back('{16'h000E, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0110000, 1'b1});
    vt.push_back('{16'h000F, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'b0111000, 1'b1});
    // other digits, dp, blank, leading-zero suppression
    vt.push_back('{16'h12A0, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'b0001000, 1'b1});
    vt.push_back('{16'h12A0, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'b1001111, 1'b1});
    vt.push_back('{16'h0005, 4'h1, 4'h0, 1'b0, 0, 4'b1110, 7'b0100100, 1'b0});
    vt.push_back('{16'h1234, 4'h4, 4'h4, 1'b0, 2, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0030, 4'h0, 4'h0, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0030, 4'h0, 4'h0, 1'b1, 2, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0030, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'b0000110, 1'b1});
    vt.push_back('{16'h0030, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'b0000001, 1'b1});
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 1, 4'b1111, 7'b1111111, 1'b1});
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'b0000001, 1'b1});
    vt.push_back('{16'h0000, 4'h8, 4'h0, 1'b1, 3, 4'b0111, 7'b1111111, 1'b0});
    vt.push_back('{16'h0300, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'b0000001, 1'b1});
    vt.push_back('{16'h0000, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'b0000001, 1'b1});

    // Reset: outputs idle and held while clocked, loads ignored
    ld = 1'b1; val = 16'hFFFF; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dpo), 32'h1);
      chk("rst_frame", 32'(frame), 32'h0);
      chk("rst_pending", 32'(pend), 32'h0);
    end
    ld = 1'b0; en = 1'b0; val = 16'h0;
    rstn = 1'b1;
    model_reset();
    tick();

    // Table vectors
    foreach (vt[i]) begin
      apply(vt[i].v, vt[i].dp, vt[i].bl, vt[i].lz);
      goto(vt[i].dig * P + DC + 1);
      chk($sformatf("vec%0d_an", i), 32'(an), 32'(vt[i].an));
      chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vt[i].seg));
      chk($sformatf("vec%0d_dp", i), 32'(dpo), 32'(vt[i].dpo));
    end

    // Load and scan: dead phase then digit 0, frame period
    apply(16'h12A0, 4'h0, 4'h0, 1'b0);
    tick(); chk("scan_dead0", 32'(an), 32'hF);
    tick(); chk("scan_dead1", 32'(an), 32'hF);
    tick(); chk("scan_d0_an", 32'(an), 32'(4'b1110));
    chk("scan_d0_seg", 32'(seg), 32'(7'b0000001));
    cnt = 0;
    while (!frame && cnt < 100) begin tick(); cnt++; end
    cnt = 0;
    do begin tick(); cnt++; end while (!frame && cnt < 100);
    chk("frame_period", 32'(cnt), 32'd32);

    // Tear-free update: 1111 overwritten by 2222 before the boundary
    goto(9);
    ld = 1'b1; val = 16'h1111; tick(); ld = 1'b0;
    goto(19);
    ld = 1'b1; val = 16'h2222; tick(); ld = 1'b0;
    chk("tear_pending", 32'(pend), 32'h1);
    goto(26);
    chk("tear_old_d3", 32'(seg), 32'(7'b1001111));
    goto(P + 3);
    chk("tear_new_d1", 32'(seg), 32'(7'b0010010));
    chk("tear_pending_clr", 32'(pend), 32'h0);

    // Load in the boundary cycle lands one frame later
    goto(30);
    ld = 1'b1; val = 16'h4444; tick(); ld = 1'b0;
    chk("coll_pending", 32'(pend), 32'h1);
    goto(2);
    chk("coll_old", 32'(seg), 32'(7'b0010010));
    chk("coll_pending_hold", 32'(pend), 32'h1);
    goto(2);
    chk("coll_new", 32'(seg), 32'(7'b1001100));
    chk("coll_pending_clr", 32'(pend), 32'h0);

    // Disable mid-slot, then re-enable from digit 0 dead phase
    goto(19);
    en = 1'b0; tick();
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_seg", 32'(seg), 32'h7F);
    en = 1'b1; tick();
    chk("reen_dead", 32'(an), 32'hF);
    tick(); tick();
    chk("reen_d0_an", 32'(an), 32'(4'b1110));
    chk("reen_d0_seg", 32'(seg), 32'(7'b1001100));

    // Asynchronous reset mid-slot clears the active buffer
    goto(12);
    rstn = 1'b0;
    #1;
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_pending", 32'(pend), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    goto(2);
    chk("arst_d0_an", 32'(an), 32'(4'b1110));
    chk("arst_d0_seg", 32'(seg), 32'(7'b0000001));
    goto(P + 2);
    chk("arst_d1_seg", 32'(seg), 32'(7'b0000001));

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 63) != 0);
      ld = ($urandom_range(0, 15) == 0);
      val = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 0) val[4*k +: 4] = 4'h0;
      end
      dpi = 4'($urandom);
      blk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 31) == 0) lzs = ~lzs;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
